// File: rtl/conv_ch_acc_pkg.sv
// Shared helpers for the channel-serial convolution accumulator and its dot product.
package conv_ch_acc_pkg;

   // Accumulator width that holds KK*NUM_CH signed products plus bias without overflow.
   function automatic int acc_width(input int bit_width, input int kk, input int num_ch);
      return 2 * bit_width + $clog2(kk * num_ch) + 1;
   endfunction

   // Lowest bit of window/filter element idx in the packed bus.
   function automatic int win_lsb(input int idx, input int bit_width);
      return bit_width * idx;
   endfunction

   // Clamp a signed value into the range of a width-bit two's complement number.
   function automatic logic signed [63:0] sat_to(input logic signed [63:0] value, input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/conv_ch_acc_if.sv
// Input beat stream and output pixel stream of the channel-serial accumulator.
interface conv_ch_acc_if #(
   parameter int BIT_WIDTH = 8,
   parameter int KK        = 25,
   parameter int OUT_WIDTH = 32
);
   logic                      s_valid;
   logic                      s_ready;
   logic [BIT_WIDTH*KK-1:0]   s_win;
   logic [BIT_WIDTH*KK-1:0]   s_filt;
   logic [BIT_WIDTH-1:0]      bias;
   logic                      relu_en;
   logic                      m_valid;
   logic                      m_ready;
   logic [OUT_WIDTH-1:0]      m_data;
   logic                      busy;

   modport slave (
      input  s_valid, s_win, s_filt, bias, relu_en, m_ready,
      output s_ready, m_valid, m_data, busy
   );

   modport master (
      output s_valid, s_win, s_filt, bias, relu_en, m_ready,
      input  s_ready, m_valid, m_data, busy
   );
endinterface

// File: rtl/conv_ch_acc_dot.sv
// Combinational KK-term signed dot product, sign-extended to the accumulator width.
module conv_dot
   import conv_ch_acc_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int KK        = 25,
   parameter int ACC_WIDTH = 24
) (
   input  logic [BIT_WIDTH*KK-1:0]   win,
   input  logic [BIT_WIDTH*KK-1:0]   filt,
   output logic signed [ACC_WIDTH-1:0] dot
);

   logic signed [BIT_WIDTH-1:0]   a;
   logic signed [BIT_WIDTH-1:0]   b;
   logic signed [2*BIT_WIDTH-1:0] prod;

   // Sum every element product; products are widened before adding so nothing wraps.
   always_comb begin
      dot  = '0;
      a    = '0;
      b    = '0;
      prod = '0;
      for (int i = 0; i < KK; i++) begin
         a    = win[win_lsb(i, BIT_WIDTH) +: BIT_WIDTH];
         b    = filt[win_lsb(i, BIT_WIDTH) +: BIT_WIDTH];
         prod = a * b;
         dot  = dot + ACC_WIDTH'(prod);
      end
   end

endmodule

// File: rtl/conv_ch_acc.sv
// Channel-serial convolution accumulator: one channel per beat, bias/ReLU/saturate on the last.
module conv_ch_acc
   import conv_ch_acc_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int OUT_WIDTH = 32,
   parameter int NUM_CH    = 4,
   parameter int KSIZE     = 5
) (
   input  logic           clk,
   input  logic           rst,
   conv_ch_acc_if.slave   bus
);

   localparam int KK        = KSIZE * KSIZE;
   localparam int ACC_WIDTH = acc_width(BIT_WIDTH, KK, NUM_CH);
   localparam int CNT_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_WIDTH-1:0] LAST_CH = CNT_WIDTH'(NUM_CH - 1);

   logic                          stall;
   logic                          accept;
   logic                          last_ch;
   logic [CNT_WIDTH-1:0]          ch_cnt;
   logic signed [ACC_WIDTH-1:0]   dot;
   logic signed [ACC_WIDTH-1:0]   psum;
   logic                          psum_v;
   logic                          psum_last;
   logic signed [BIT_WIDTH-1:0]   bias_q;
   logic                          relu_q;
   logic signed [ACC_WIDTH-1:0]   acc;
   logic signed [ACC_WIDTH-1:0]   sum;
   logic signed [OUT_WIDTH-1:0]   result;
   logic                          out_valid;
   logic signed [OUT_WIDTH-1:0]   out_data;

   // A held output freezes the whole pipeline, so at most the beat in psum is retained.
   assign stall       = out_valid & ~bus.m_ready;
   assign accept      = bus.s_valid & ~stall;
   assign last_ch     = (ch_cnt == LAST_CH);
   assign bus.s_ready = ~stall;
   assign bus.m_valid = out_valid;
   assign bus.m_data  = out_data;
   assign bus.busy    = (ch_cnt != '0) | psum_v;

   conv_dot #(
      .BIT_WIDTH (BIT_WIDTH),
      .KK        (KK),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_dot (
      .win  (bus.s_win),
      .filt (bus.s_filt),
      .dot  (dot)
   );

   // Channel counter walks 0..NUM_CH-1 over accepted beats and wraps on the last channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_cnt <= '0;
      end else if (accept) begin
         ch_cnt <= last_ch ? '0 : ch_cnt + CNT_WIDTH'(1);
      end
   end

   // Stage 1 registers the per-channel dot product; bias and ReLU are captured on the last beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         psum      <= '0;
         psum_v    <= 1'b0;
         psum_last <= 1'b0;
         bias_q    <= '0;
         relu_q    <= 1'b0;
      end else if (!stall) begin
         psum_v <= accept;
         if (accept) begin
            psum      <= dot;
            psum_last <= last_ch;
            if (last_ch) begin
               bias_q <= $signed(bus.bias);
               relu_q <= bus.relu_en;
            end
         end
      end
   end

   // Final value of a frame: running sum plus last partial plus bias, ReLU, then saturation.
   always_comb begin
      sum = acc + psum + ACC_WIDTH'(bias_q);
      if (relu_q && sum[ACC_WIDTH-1]) begin
         sum = '0;
      end
      result = OUT_WIDTH'(sat_to(64'(sum), OUT_WIDTH));
   end

   // Stage 2 accumulates partials and loads the output register when a frame completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (!stall) begin
         out_valid <= psum_v & psum_last;
         if (psum_v) begin
            if (psum_last) begin
               acc      <= '0;
               out_data <= result;
            end else begin
               acc <= acc + psum;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_ch_acc.sv
// Self-checking bench: default, 12-bit-output and single-channel 3x3 instances of conv_ch_acc.
module tb_conv_ch_acc;

   localparam int BW  = 8;
   localparam int KK  = 25;
   localparam int NCH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int assert_count = 0;
   int fail_count   = 0;

   longint frame_sum = 0;
   int     beat_cnt  = 0;
   longint exp_q[$];
   bit     rand_done = 0;

   conv_ch_acc_if #(.BIT_WIDTH(8), .KK(25), .OUT_WIDTH(32)) ifc1 ();
   conv_ch_acc_if #(.BIT_WIDTH(8), .KK(25), .OUT_WIDTH(12)) ifc2 ();
   conv_ch_acc_if #(.BIT_WIDTH(8), .KK(9),  .OUT_WIDTH(32)) ifc3 ();

   conv_ch_acc #(.BIT_WIDTH(8), .OUT_WIDTH(32), .NUM_CH(4), .KSIZE(5)) dut1 (
      .clk (clk), .rst (rst), .bus (ifc1.slave));
   conv_ch_acc #(.BIT_WIDTH(8), .OUT_WIDTH(12), .NUM_CH(4), .KSIZE(5)) dut2 (
      .clk (clk), .rst (rst), .bus (ifc2.slave));
   conv_ch_acc #(.BIT_WIDTH(8), .OUT_WIDTH(32), .NUM_CH(1), .KSIZE(3)) dut3 (
      .clk (clk), .rst (rst), .bus (ifc3.slave));

   // The 12-bit instance sees exactly the stimulus of the default instance.
   assign ifc2.s_valid = ifc1.s_valid;
   assign ifc2.s_win   = ifc1.s_win;
   assign ifc2.s_filt  = ifc1.s_filt;
   assign ifc2.bias    = ifc1.bias;
   assign ifc2.relu_en = ifc1.relu_en;
   assign ifc2.m_ready = ifc1.m_ready;

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      assert_count++;
      assert (observed === expected)
      else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic longint dotModel(input logic [BW*KK-1:0] w, input logic [BW*KK-1:0] f);
      longint s;
      s = 0;
      for (int i = 0; i < KK; i++) begin
         s += longint'($signed(w[BW*i +: BW])) * longint'($signed(f[BW*i +: BW]));
      end
      return s;
   endfunction

   function automatic longint satModel(input longint v, input int width);
      longint hi;
      longint lo;
      hi = (longint'(1) << (width - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic logic [BW*KK-1:0] fillVec(input logic [BW-1:0] v);
      return {KK{v}};
   endfunction

   function automatic logic [BW*KK-1:0] randVec();
      logic [BW*KK-1:0] v;
      for (int i = 0; i < KK; i++) v[BW*i +: BW] = BW'($urandom_range(0, 255));
      return v;
   endfunction

   // Reference model: record accepted beats, form frame results, check every output handshake.
   always @(negedge clk) begin
      longint r;
      if (!rst) begin
         checkOutput("s_ready_rule", longint'(ifc1.s_ready), longint'(!(ifc1.m_valid && !ifc1.m_ready)));
         if (ifc1.s_valid && ifc1.s_ready) begin
            frame_sum += dotModel(ifc1.s_win, ifc1.s_filt);
            beat_cnt++;
            if (beat_cnt == NCH) begin
               r = frame_sum + longint'($signed(ifc1.bias));
               if (ifc1.relu_en && r < 0) r = 0;
               exp_q.push_back(r);
               frame_sum = 0;
               beat_cnt  = 0;
            end
         end
         if (ifc1.m_valid && ifc1.m_ready) begin
            checkOutput("output_expected", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               checkOutput("m_data_w32", longint'($signed(ifc1.m_data)), satModel(exp_q[0], 32));
               checkOutput("m_data_w12", longint'($signed(ifc2.m_data)), satModel(exp_q[0], 12));
               checkOutput("m_valid_w12", longint'(ifc2.m_valid), 1);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // Present one beat and hold it until the DUT takes it.
   task automatic applyStimulus(input logic [BW*KK-1:0] w, input logic [BW*KK-1:0] f,
                                input logic [BW-1:0] b, input logic r);
      bit got;
      got = 0;
      ifc1.s_valid = 1'b1;
      ifc1.s_win   = w;
      ifc1.s_filt  = f;
      ifc1.bias    = b;
      ifc1.relu_en = r;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (ifc1.s_ready) got = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      checkOutput("accept_in_time", longint'(got), 1);
      @(posedge clk);
      #1;
      ifc1.s_valid = 1'b0;
   endtask

   task automatic sendFrame(input logic [BW*KK-1:0] w, input logic [BW*KK-1:0] f,
                            input logic [BW-1:0] b, input logic r);
      for (int i = 0; i < NCH; i++) applyStimulus(w, f, b, r);
   endtask

   task automatic expectResult(input string tag, input longint v32, input longint v12);
      bit seen;
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (ifc1.m_valid) seen = 1;
      end
      checkOutput({tag, "_valid"}, longint'(seen), 1);
      checkOutput({tag, "_w32"}, longint'($signed(ifc1.m_data)), v32);
      checkOutput({tag, "_w12"}, longint'($signed(ifc2.m_data)), v12);
      @(posedge clk);
      #1;
   endtask

   // Guard against a hung simulation.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed and randomized stimulus sequence.
   initial begin
      logic [BW*KK-1:0] ones;
      logic [BW*KK-1:0] negs;
      bit seen;
      ones = fillVec(8'd1);
      negs = fillVec(8'hFF);
      ifc1.s_valid = 1'b0; ifc1.s_win = '0; ifc1.s_filt = '0;
      ifc1.bias = '0; ifc1.relu_en = 1'b0; ifc1.m_ready = 1'b1;
      ifc3.s_valid = 1'b0; ifc3.s_win = '0; ifc3.s_filt = '0;
      ifc3.bias = '0; ifc3.relu_en = 1'b0; ifc3.m_ready = 1'b1;

      // Reset state.
      repeat (2) @(negedge clk);
      checkOutput("rst_m_valid", longint'(ifc1.m_valid), 0);
      checkOutput("rst_m_data", longint'(ifc1.m_data), 0);
      checkOutput("rst_busy", longint'(ifc1.busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_s_ready", longint'(ifc1.s_ready), 1);
      @(posedge clk); #1;

      // All ones, bias 3: result visible on the second cycle after the last accept.
      applyStimulus(ones, ones, 8'd3, 1'b0);
      applyStimulus(ones, ones, 8'd3, 1'b0);
      @(negedge clk);
      checkOutput("busy_mid_frame", longint'(ifc1.busy), 1);
      @(posedge clk); #1;
      applyStimulus(ones, ones, 8'd3, 1'b0);
      applyStimulus(ones, ones, 8'd3, 1'b0);
      @(negedge clk);
      checkOutput("latency_early", longint'(ifc1.m_valid), 0);
      @(negedge clk);
      checkOutput("latency_valid", longint'(ifc1.m_valid), 1);
      checkOutput("t1_data", longint'($signed(ifc1.m_data)), 103);
      @(posedge clk); #1;

      // ReLU on and off for a negative sum.
      sendFrame(ones, negs, 8'd0, 1'b1);
      expectResult("relu_on", 0, 0);
      sendFrame(ones, negs, 8'd0, 1'b0);
      expectResult("relu_off", -100, -100);

      // Saturation at the 12-bit output, full value at 32 bits.
      sendFrame(fillVec(8'd127), fillVec(8'd127), 8'd0, 1'b0);
      expectResult("sat_pos", 1612900, 2047);
      sendFrame(fillVec(8'h80), fillVec(8'd127), 8'd0, 1'b0);
      expectResult("sat_neg", -1625600, -2048);

      // Two back-to-back frames with the first output held for three cycles.
      ifc1.m_ready = 1'b0;
      fork
         begin
            sendFrame(ones, ones, 8'd0, 1'b0);
            sendFrame(fillVec(8'd2), fillVec(8'd3), 8'hFB, 1'b0);
         end
         begin
            seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
               @(negedge clk);
               if (ifc1.m_valid) seen = 1;
            end
            checkOutput("stall_first_valid", longint'(seen), 1);
            for (int k = 0; k < 3; k++) begin
               if (k > 0) @(negedge clk);
               checkOutput("stall_s_ready", longint'(ifc1.s_ready), 0);
               checkOutput("stall_m_data", longint'($signed(ifc1.m_data)), 100);
               @(posedge clk); #1;
            end
            ifc1.m_ready = 1'b1;
         end
      join
      expectResult("after_stall", 595, 595);

      // Reset in the middle of a frame discards the partial sum.
      applyStimulus(ones, ones, 8'd0, 1'b0);
      applyStimulus(ones, ones, 8'd0, 1'b0);
      rst = 1'b1;
      frame_sum = 0;
      beat_cnt  = 0;
      @(negedge clk);
      checkOutput("midrst_busy", longint'(ifc1.busy), 0);
      checkOutput("midrst_m_valid", longint'(ifc1.m_valid), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postrst_busy", longint'(ifc1.busy), 0);
      checkOutput("postrst_m_valid", longint'(ifc1.m_valid), 0);
      checkOutput("postrst_s_ready", longint'(ifc1.s_ready), 1);
      @(posedge clk); #1;
      sendFrame(ones, ones, 8'd0, 1'b0);
      expectResult("no_residue", 100, 100);

      // Random frames under random backpressure, checked by the reference model.
      fork
         begin
            for (int n = 0; n < 20 * NCH; n++) begin
               applyStimulus(randVec(), randVec(), BW'($urandom_range(0, 255)),
                             1'($urandom_range(0, 1)));
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               ifc1.m_ready = ($urandom_range(0, 3) != 0);
            end
            ifc1.m_ready = 1'b1;
         end
      join
      for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
      #1;
      checkOutput("drain_empty", longint'(exp_q.size()), 0);
      checkOutput("drain_busy", longint'(ifc1.busy), 0);

      // Single channel, 3x3 kernel: one result per cycle after two cycles.
      ifc3.s_win  = {9{8'd2}};
      ifc3.s_filt = {9{8'd3}};
      ifc3.bias   = 8'hFC;
      ifc3.s_valid = 1'b1;
      @(negedge clk);
      checkOutput("c1_s_ready", longint'(ifc3.s_ready), 1);
      checkOutput("c1_pre_valid", longint'(ifc3.m_valid), 0);
      @(negedge clk);
      checkOutput("c1_lat1_valid", longint'(ifc3.m_valid), 0);
      checkOutput("c1_lat1_busy", longint'(ifc3.busy), 1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput("c1_valid", longint'(ifc3.m_valid), 1);
         checkOutput("c1_data", longint'($signed(ifc3.m_data)), 50);
      end
      @(posedge clk); #1;
      ifc3.s_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("c1_idle_valid", longint'(ifc3.m_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
